// File: rtl/legup_write_buffer.sv
// legup_write_buffer
//
// Posted-write buffer between the write-through cache's Avalon master and the
// DDR2 memory interface. Single-word cache stores are absorbed into a small
// FIFO so the cache can return to idle at once. Cache-line read bursts are
// only issued once every buffered write has been retired, which keeps reads
// ordered behind earlier writes.
//
// Ports
//   clk, reset               rising-edge clock, asynchronous active-high reset
//   avs_*                    Avalon slave side, driven by the cache
//     avs_address/byteenable/writedata/write   posted write command
//     avs_read/burstcount                      read burst command
//     avs_beginbursttransfer                   accepted but unused
//     avs_readdata/readdatavalid               forwarded read beats
//     avs_waitrequest                          stall back to the cache
//   avm_*                    Avalon master side, towards memory
//     avm_address/byteenable/burstcount        command fields (mux of FIFO head
//                                              or captured read command)
//     avm_write/writedata                      retiring FIFO head
//     avm_read/beginbursttransfer              read command
//     avm_readdata/readdatavalid/waitrequest   memory responses and stall
module legup_write_buffer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned BURST_WIDTH = 3,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic [ADDR_WIDTH-1:0]     avs_address,
  input  logic [DATA_WIDTH/8-1:0]   avs_byteenable,
  input  logic                      avs_read,
  input  logic                      avs_write,
  input  logic [DATA_WIDTH-1:0]     avs_writedata,
  input  logic                      avs_beginbursttransfer,
  input  logic [BURST_WIDTH-1:0]    avs_burstcount,
  output logic [DATA_WIDTH-1:0]     avs_readdata,
  output logic                      avs_readdatavalid,
  output logic                      avs_waitrequest,

  input  logic [DATA_WIDTH-1:0]     avm_readdata,
  input  logic                      avm_readdatavalid,
  input  logic                      avm_waitrequest,
  output logic [ADDR_WIDTH-1:0]     avm_address,
  output logic                      avm_beginbursttransfer,
  output logic [BURST_WIDTH-1:0]    avm_burstcount,
  output logic [DATA_WIDTH/8-1:0]   avm_byteenable,
  output logic                      avm_read,
  output logic                      avm_write,
  output logic [DATA_WIDTH-1:0]     avm_writedata
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_ISSUE = 2'd1,
    READ_WAIT  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // ---------------------------------------------------------------------------
  // Write FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] fifo_addr [DEPTH];
  logic [BE_WIDTH-1:0]   fifo_be   [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic full;
  logic empty;
  logic push;
  logic pop;

  logic [ADDR_WIDTH-1:0] head_addr;
  logic [BE_WIDTH-1:0]   head_be;
  logic [DATA_WIDTH-1:0] head_data;

  // ---------------------------------------------------------------------------
  // Captured read command
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [BURST_WIDTH-1:0] rd_burst;
  logic [BE_WIDTH-1:0]    rd_be;
  logic [BURST_WIDTH-1:0] beat_count;
  logic                   issue_first;

  logic read_accept;
  logic last_beat;

  // Burst start marker from the cache carries no information here; the read
  // command is fully described by avs_read and avs_burstcount.
  logic unused_begin;
  assign unused_begin = avs_beginbursttransfer;

  // Full/empty come from the registered count only, never from this cycle's
  // push/pop, so a pop cannot open a slot for a same-cycle push.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign head_addr = fifo_addr[rd_ptr];
  assign head_be   = fifo_be[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  assign push = avs_write & ~full;
  assign pop  = avm_write & ~avm_waitrequest;

  // A read is taken only with nothing buffered and no competing write; on a
  // simultaneous read/write the write wins and the read keeps stalling.
  assign read_accept = (state == IDLE) & avs_read & empty & ~avs_write;

  assign last_beat = (state == READ_WAIT) & avm_readdatavalid &
                     ((beat_count + BURST_WIDTH'(1)) == rd_burst);

  // ---------------------------------------------------------------------------
  // FIFO registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Entries are cleared too so the idle head (and thus avm_address)
      // reads as zero straight out of reset.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_addr[i] <= '0;
        fifo_be[i]   <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= avs_address;
        fifo_be[wr_ptr]   <= avs_byteenable;
        fifo_data[wr_ptr] <= avs_writedata;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read command capture and beat counting
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr     <= '0;
      rd_burst    <= '0;
      rd_be       <= '0;
      beat_count  <= '0;
      issue_first <= 1'b0;
    end else begin
      if (read_accept) begin
        rd_addr     <= avs_address;
        rd_burst    <= avs_burstcount;
        rd_be       <= '1;
        beat_count  <= '0;
        issue_first <= 1'b1;
      end else if (state == READ_ISSUE) begin
        // Begin-burst is a single pulse even if memory stalls the command.
        issue_first <= 1'b0;
      end

      // Beats arriving outside READ_WAIT are not counted.
      if ((state == READ_WAIT) && avm_readdatavalid) begin
        beat_count <= beat_count + BURST_WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (read_accept) state_next = READ_ISSUE;
      end
      READ_ISSUE: begin
        if (!avm_waitrequest) state_next = READ_WAIT;
      end
      READ_WAIT: begin
        if (last_beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read FSM: outputs and command mux
  // ---------------------------------------------------------------------------
  always_comb begin
    avm_read               = 1'b0;
    avm_write              = 1'b0;
    avm_beginbursttransfer = 1'b0;
    avm_address            = head_addr;
    avm_burstcount         = BURST_WIDTH'(1);
    avm_byteenable         = head_be;
    unique case (state)
      IDLE: begin
        avm_write = ~empty;
      end
      READ_ISSUE: begin
        avm_read               = 1'b1;
        avm_beginbursttransfer = issue_first;
        avm_address            = rd_addr;
        avm_burstcount         = rd_burst;
        avm_byteenable         = rd_be;
      end
      READ_WAIT: begin
        avm_write = 1'b0;
      end
      default: begin
        avm_write = 1'b0;
      end
    endcase
  end

  assign avm_writedata = head_data;

  // ---------------------------------------------------------------------------
  // Slave-side stall and read data forwarding
  // ---------------------------------------------------------------------------
  always_comb begin
    avs_waitrequest = 1'b0;
    if (avs_write) begin
      avs_waitrequest = full;
    end else if (avs_read) begin
      avs_waitrequest = (state != IDLE) | ~empty;
    end
  end

  assign avs_readdata      = avm_readdata;
  assign avs_readdatavalid = avm_readdatavalid;

endmodule

// File: tb/tb_legup_write_buffer.sv
// Directed testbench for legup_write_buffer: posted writes, full-FIFO stall,
// reads queued behind writes, stalled read command, concurrent push/pop and
// asynchronous reset in the middle of a read burst.
module tb_legup_write_buffer;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned BW = 3;
  localparam int unsigned BEW = DW / 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [AW-1:0]  avs_address;
  logic [BEW-1:0] avs_byteenable;
  logic           avs_read;
  logic           avs_write;
  logic [DW-1:0]  avs_writedata;
  logic           avs_beginbursttransfer;
  logic [BW-1:0]  avs_burstcount;
  logic [DW-1:0]  avs_readdata;
  logic           avs_readdatavalid;
  logic           avs_waitrequest;
  logic [DW-1:0]  avm_readdata;
  logic           avm_readdatavalid;
  logic           avm_waitrequest;
  logic [AW-1:0]  avm_address;
  logic           avm_beginbursttransfer;
  logic [BW-1:0]  avm_burstcount;
  logic [BEW-1:0] avm_byteenable;
  logic           avm_read;
  logic           avm_write;
  logic [DW-1:0]  avm_writedata;

  int tests_run = 0;
  int tests_failed = 0;

  legup_write_buffer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BURST_WIDTH(BW),
    .DEPTH      (4)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .avs_address           (avs_address),
    .avs_byteenable        (avs_byteenable),
    .avs_read              (avs_read),
    .avs_write             (avs_write),
    .avs_writedata         (avs_writedata),
    .avs_beginbursttransfer(avs_beginbursttransfer),
    .avs_burstcount        (avs_burstcount),
    .avs_readdata          (avs_readdata),
    .avs_readdatavalid     (avs_readdatavalid),
    .avs_waitrequest       (avs_waitrequest),
    .avm_readdata          (avm_readdata),
    .avm_readdatavalid     (avm_readdatavalid),
    .avm_waitrequest       (avm_waitrequest),
    .avm_address           (avm_address),
    .avm_beginbursttransfer(avm_beginbursttransfer),
    .avm_burstcount        (avm_burstcount),
    .avm_byteenable        (avm_byteenable),
    .avm_read              (avm_read),
    .avm_write             (avm_write),
    .avm_writedata         (avm_writedata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs are sampled one time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    avs_address            = '0;
    avs_byteenable         = '0;
    avs_read               = 1'b0;
    avs_write              = 1'b0;
    avs_writedata          = '0;
    avs_beginbursttransfer = 1'b0;
    avs_burstcount         = '0;
    avm_readdata           = '0;
    avm_readdatavalid      = 1'b0;
    avm_waitrequest        = 1'b0;
  endtask

  task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    avs_write      = 1'b1;
    avs_read       = 1'b0;
    avs_address    = a;
    avs_writedata  = d;
    avs_byteenable = 4'hF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    #2;
    check("rst_avm_read",  avm_read, 0);
    check("rst_avm_write", avm_write, 0);
    check("rst_begin",     avm_beginbursttransfer, 0);
    check("rst_avs_wait",  avs_waitrequest, 0);
    check("rst_avm_addr",  avm_address, 0);
    step(); step();
    reset = 1'b0;

    // ---- 1: single write ----
    drive_write(32'h100, 32'hDEADBEEF);
    #1;
    check("t1_accept",   avs_waitrequest, 0);
    check("t1_noearly",  avm_write, 0);
    step();
    avs_write = 1'b0;
    #1;
    check("t1_avm_write", avm_write, 1);
    check("t1_addr",      avm_address, 32'h100);
    check("t1_data",      avm_writedata, 32'hDEADBEEF);
    check("t1_be",        avm_byteenable, 4'hF);
    check("t1_burst",     avm_burstcount, 1);
    step();
    #1;
    check("t1_single",    avm_write, 0);

    // ---- 2: full FIFO ----
    avm_waitrequest = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_write(32'h1000 + 32'(4 * i), 32'(i));
      #1;
      check("t2_accept", avs_waitrequest, 0);
      step();
    end
    drive_write(32'h1014, 32'd5);
    avm_waitrequest = 1'b0;
    #1;
    check("t2_full_stall", avs_waitrequest, 1);
    check("t2_head1",      avm_writedata, 1);
    step();
    #1;
    check("t2_fifth_acc",  avs_waitrequest, 0);
    check("t2_head2",      avm_writedata, 2);
    step();
    avs_write = 1'b0;
    for (int j = 3; j <= 5; j++) begin
      #1;
      check("t2_retire_wr", avm_write, 1);
      check("t2_retire_d",  avm_writedata, 32'(j));
      step();
    end
    #1;
    check("t2_drained", avm_write, 0);

    // ---- 3: read behind two writes ----
    avm_waitrequest = 1'b1;
    drive_write(32'hA0, 32'hA);
    step();
    drive_write(32'hB0, 32'hB);
    step();
    avs_write       = 1'b0;
    avs_read        = 1'b1;
    avs_address     = 32'h200;
    avs_burstcount  = 3'd4;
    avm_waitrequest = 1'b0;
    #1;
    check("t3_wait0",  avs_waitrequest, 1);
    check("t3_popA",   avm_writedata, 32'hA);
    step();
    #1;
    check("t3_wait1",  avs_waitrequest, 1);
    check("t3_popB",   avm_writedata, 32'hB);
    step();
    #1;
    check("t3_accept", avs_waitrequest, 0);
    check("t3_nowr",   avm_write, 0);
    step();
    avs_read = 1'b0;
    avs_address = '0;
    avs_burstcount = '0;
    #1;
    check("t3_read",  avm_read, 1);
    check("t3_begin", avm_beginbursttransfer, 1);
    check("t3_addr",  avm_address, 32'h200);
    check("t3_burst", avm_burstcount, 4);
    check("t3_be",    avm_byteenable, 4'hF);
    check("t3_nowr2", avm_write, 0);
    step();
    for (int b = 0; b < 4; b++) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = 32'h11 * 32'(b + 1);
      #1;
      check("t3_rvalid", avs_readdatavalid, 1);
      check("t3_rdata",  avs_readdata, 32'h11 * 32'(b + 1));
      check("t3_noread", avm_read, 0);
      step();
    end
    avm_readdatavalid = 1'b0;

    // ---- 4: stalled read command, stray beat before READ_WAIT ----
    avs_read        = 1'b1;
    avs_address     = 32'h300;
    avs_burstcount  = 3'd2;
    avm_waitrequest = 1'b1;
    #1;
    check("t4_accept", avs_waitrequest, 0);
    step();
    avs_read = 1'b0;
    avs_address = '0;
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h99;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) avm_waitrequest = 1'b0;
      #1;
      check("t4_read",  avm_read, 1);
      check("t4_begin", avm_beginbursttransfer, (k == 0));
      check("t4_addr",  avm_address, 32'h300);
      check("t4_burst", avm_burstcount, 2);
      if (k == 0) begin
        check("t4_stray_fwd", avs_readdatavalid, 1);
        check("t4_stray_dat", avs_readdata, 32'h99);
      end
      avm_readdatavalid = 1'b0;
      step();
    end
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hA1;
    #1;
    check("t4_noread", avm_read, 0);
    step();
    avm_readdata = 32'hA2;
    step();
    avm_readdatavalid = 1'b0;

    // ---- 5: concurrent push/pop at count 2 ----
    avm_waitrequest = 1'b1;
    drive_write(32'h510, 32'h51);
    #1;
    check("t5_acc51", avs_waitrequest, 0);
    step();
    drive_write(32'h520, 32'h52);
    #1;
    check("t5_idle_wr", avm_write, 1);
    check("t5_head51a", avm_writedata, 32'h51);
    step();
    drive_write(32'h530, 32'h53);
    avm_waitrequest = 1'b0;
    #1;
    check("t5_head51b", avm_writedata, 32'h51);
    check("t5_acc53",   avs_waitrequest, 0);
    step();
    avm_waitrequest = 1'b1;
    drive_write(32'h540, 32'h54);
    #1;
    check("t5_head52", avm_writedata, 32'h52);
    step();
    drive_write(32'h550, 32'h55);
    #1;
    check("t5_acc55", avs_waitrequest, 0);
    step();
    drive_write(32'h560, 32'h56);
    #1;
    check("t5_full", avs_waitrequest, 1);
    step();
    avs_write = 1'b0;
    avm_waitrequest = 1'b0;
    for (int j = 2; j <= 5; j++) begin
      #1;
      check("t5_order", avm_writedata, 32'h50 + 32'(j));
      step();
    end
    #1;
    check("t5_drained", avm_write, 0);

    // ---- 6: asynchronous reset mid-burst ----
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    avs_read       = 1'b1;
    avs_address    = 32'h600;
    avs_burstcount = 3'd4;
    #1;
    check("t6_accept", avs_waitrequest, 0);
    step();
    avs_read = 1'b0;
    #1;
    check("t6_read", avm_read, 1);
    step();
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hC1;
    drive_write(32'h610, 32'h61);
    step();
    avm_readdata = 32'hC2;
    drive_write(32'h620, 32'h62);
    step();
    avm_readdatavalid = 1'b0;
    drive_write(32'h630, 32'h63);
    #1;
    check("t6_held_wr", avm_write, 0);
    step();
    idle_inputs();
    avs_read = 1'b1;
    #1;
    check("t6_pre_wait", avs_waitrequest, 1);
    check("t6_pre_addr", avm_address, 32'h610);
    reset = 1'b1;
    #1;
    check("t6_rst_wait",  avs_waitrequest, 0);
    check("t6_rst_addr",  avm_address, 0);
    check("t6_rst_read",  avm_read, 0);
    check("t6_rst_write", avm_write, 0);
    check("t6_rst_begin", avm_beginbursttransfer, 0);
    avs_read = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    check("t6_no_stale", avm_write, 0);
    avs_read       = 1'b1;
    avs_address    = 32'h700;
    avs_burstcount = 3'd1;
    #1;
    check("t6_new_acc", avs_waitrequest, 0);
    step();
    avs_read = 1'b0;
    #1;
    check("t6_new_read",  avm_read, 1);
    check("t6_new_begin", avm_beginbursttransfer, 1);
    check("t6_new_addr",  avm_address, 32'h700);
    check("t6_new_burst", avm_burstcount, 1);
    step();
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hD1;
    step();
    avm_readdatavalid = 1'b0;
    avs_read = 1'b1;
    avs_address = 32'h800;
    #1;
    check("t6_back_idle", avs_waitrequest, 0);
    step();
    avs_read = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
